// File: rtl/barcode_rx.sv
// barcode_rx: pulse-width decoder for the IR barcode link; narrow pulse = 0, wide pulse = 1, MSB first.
// Define BARCODE_RX_PARITY_EN for 9-pulse frames with a trailing even-parity pulse.
module barcode_rx #(
    parameter int TICK_DIV  = 16,
    parameter int PULSE_MIN = 2,
    parameter int SHORT_MAX = 12,
    parameter int PULSE_MAX = 40,
    parameter int GAP_MAX   = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXIN,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       ERR,
    output logic [1:0] ERRCODE,
    output logic       OVERRUN,
    output logic       BUSY
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] MIN_LIM   = 8'(PULSE_MIN);
    localparam logic [7:0] SHORT_LIM = 8'(SHORT_MAX);
    localparam logic [7:0] MAX_LIM   = 8'(PULSE_MAX);
    localparam logic [7:0] GAP_LIM   = 8'(GAP_MAX);
`ifdef BARCODE_RX_PARITY_EN
    localparam logic [3:0] FRAME_LEN = 4'd9;
    localparam int SHIFT_W = 8;
`else
    localparam logic [3:0] FRAME_LEN = 4'd8;
    localparam int SHIFT_W = 7;
`endif

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_WAIT_LOW} state_t;

    logic               rxMeta_q, rxSync_q;
    logic [PW-1:0]      presc_q;
    logic               tick;
    state_t             state_q;
    logic [7:0]         count_q;
    logic [3:0]         bitCnt_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [7:0]         data_q;
    logic               valid_q, err_q, overrun_q, busy_q;
    logic [1:0]         errCode_q;

    logic [7:0]         countInc_d;
    logic               newBit_d, lastBit_d, pulseEnd_d, emit_d, handshake;
    logic [7:0]         emitData_d;
`ifdef BARCODE_RX_PARITY_EN
    logic               parityBad_d;
`endif

    assign tick      = (presc_q == PW'(TICK_DIV - 1));
    assign handshake = valid_q && READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rxMeta_q <= 1'b0;
            rxSync_q <= 1'b0;
            presc_q  <= '0;
        end else begin
            rxMeta_q <= RXIN;
            rxSync_q <= rxMeta_q;
            presc_q  <= tick ? '0 : presc_q + PW'(1);
        end
    end

    // A pulse ends on the first low tick in HIGH; the frame's last pulse produces the byte.
    always_comb begin
        countInc_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        newBit_d   = (count_q > SHORT_LIM);
        lastBit_d  = (bitCnt_q == FRAME_LEN - 4'd1);
        pulseEnd_d = tick && (state_q == S_HIGH) && !rxSync_q && (count_q >= MIN_LIM);
`ifdef BARCODE_RX_PARITY_EN
        parityBad_d = (^shift_q) ^ newBit_d;
        emitData_d  = shift_q;
        emit_d      = pulseEnd_d && lastBit_d && !parityBad_d;
`else
        emitData_d  = {shift_q, newBit_d};
        emit_d      = pulseEnd_d && lastBit_d;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            errCode_q <= 2'b00;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            err_q     <= 1'b0;
            overrun_q <= 1'b0;

            // A same-cycle handshake frees the buffer, so the new byte still loads.
            if (emit_d) begin
                if (!valid_q || handshake) begin
                    data_q  <= emitData_d;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (handshake) begin
                valid_q <= 1'b0;
            end

            if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        bitCnt_q <= '0;
                        if (rxSync_q) begin
                            state_q <= S_HIGH;
                            count_q <= 8'd1;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (rxSync_q) begin
                            count_q <= countInc_d;
                            if (countInc_d > MAX_LIM) begin
                                err_q     <= 1'b1;
                                errCode_q <= 2'b10;
                                state_q   <= S_WAIT_LOW;
                                busy_q    <= 1'b0;
                            end
                        end else if (count_q < MIN_LIM) begin
                            err_q     <= 1'b1;
                            errCode_q <= 2'b01;
                            state_q   <= S_IDLE;
                            bitCnt_q  <= '0;
                            busy_q    <= 1'b0;
                        end else if (lastBit_d) begin
`ifdef BARCODE_RX_PARITY_EN
                            if (parityBad_d) begin
                                err_q     <= 1'b1;
                                errCode_q <= 2'b00;
                            end
`endif
                            state_q  <= S_IDLE;
                            bitCnt_q <= '0;
                            busy_q   <= 1'b0;
                        end else begin
                            shift_q  <= {shift_q[SHIFT_W-2:0], newBit_d};
                            bitCnt_q <= bitCnt_q + 4'd1;
                            state_q  <= S_LOW;
                            count_q  <= 8'd1;
                        end
                    end
                    S_LOW: begin
                        if (rxSync_q) begin
                            state_q <= S_HIGH;
                            count_q <= 8'd1;
                        end else begin
                            count_q <= countInc_d;
                            if (countInc_d >= GAP_LIM) begin
                                err_q     <= 1'b1;
                                errCode_q <= 2'b11;
                                state_q   <= S_IDLE;
                                bitCnt_q  <= '0;
                                busy_q    <= 1'b0;
                            end
                        end
                    end
                    S_WAIT_LOW: begin
                        bitCnt_q <= '0;
                        if (!rxSync_q) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign DATA    = data_q;
    assign VALID   = valid_q;
    assign ERR     = err_q;
    assign ERRCODE = errCode_q;
    assign OVERRUN = overrun_q;
    assign BUSY    = busy_q;
endmodule

// File: tb/tb_barcode_rx.sv
// tb_barcode_rx: drives tick-aligned pulse/gap segments and compares DUT events with a segment-level model.
// Honours BARCODE_RX_PARITY_EN the same way as the design.
module tb_barcode_rx;
    localparam int TD   = 4;
    localparam int PMIN = 2;
    localparam int SMAX = 12;
    localparam int PMAX = 40;
    localparam int GMAX = 64;
`ifdef BARCODE_RX_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       CLK = 1'b0;
    logic       RST, RXIN, READY;
    logic [7:0] DATA;
    logic       VALID, ERR, OVERRUN, BUSY;
    logic [1:0] ERRCODE;

    int checks = 0;
    int errors = 0;

    logic [7:0] gotBytes[$];
    logic [7:0] expBytes[$];
    logic [1:0] gotErrs[$];
    logic [1:0] expErrs[$];
    int gotOverrun = 0;
    int expOverrun = 0;

    int         mBits = 0;
    logic [8:0] mAcc  = '0;
    bit         modelFull = 0;
    bit         readyHeld = 0;

    barcode_rx #(
        .TICK_DIV(TD), .PULSE_MIN(PMIN), .SHORT_MAX(SMAX), .PULSE_MAX(PMAX), .GAP_MAX(GMAX)
    ) dut (
        .CLK(CLK), .RST(RST), .RXIN(RXIN), .DATA(DATA), .VALID(VALID), .READY(READY),
        .ERR(ERR), .ERRCODE(ERRCODE), .OVERRUN(OVERRUN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Event log taken mid-cycle: accepted bytes, error codes and overrun pulses.
    always @(negedge CLK) begin
        if (!RST) begin
            if (VALID && READY) gotBytes.push_back(DATA);
            if (ERR) gotErrs.push_back(ERRCODE);
            if (OVERRUN) gotOverrun++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic level, input int ticks);
        RXIN = level;
        repeat (ticks * TD) @(posedge CLK);
        #1;
    endtask

    // Single-entry buffer seen from the consumer side: with READY held high every byte is taken.
    task automatic modelEmit(input logic [7:0] b);
        if (modelFull && !readyHeld) begin
            expOverrun++;
        end else begin
            expBytes.push_back(b);
            if (!readyHeld) modelFull = 1;
        end
    endtask

    task automatic pulse(input int w);
        logic bitVal;
        drive(1'b1, w);
        if (w < PMIN) begin
            expErrs.push_back(2'b01);
            mBits = 0;
        end else if (w > PMAX) begin
            expErrs.push_back(2'b10);
            mBits = 0;
        end else begin
            bitVal = (w > SMAX);
            mAcc = {mAcc[7:0], bitVal};
            mBits++;
            if (mBits == FRAME) begin
`ifdef BARCODE_RX_PARITY_EN
                if (^mAcc) expErrs.push_back(2'b00);
                else modelEmit(mAcc[8:1]);
`else
                modelEmit(mAcc[7:0]);
`endif
                mBits = 0;
            end
        end
    endtask

    task automatic gap(input int g);
        drive(1'b0, g);
        if (mBits > 0 && g >= GMAX) begin
            expErrs.push_back(2'b11);
            mBits = 0;
        end
    endtask

    task automatic setReady(input bit r);
        READY = r;
        readyHeld = r;
        if (r) modelFull = 0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int nw, input int ww, input int gw);
        for (int i = 7; i >= 0; i--) begin
            pulse(b[i] ? ww : nw);
            gap(gw);
        end
`ifdef BARCODE_RX_PARITY_EN
        pulse((^b) ? ww : nw);
        gap(gw);
`endif
    endtask

    task automatic sendBits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            pulse(b[i] ? 20 : 5);
            gap(5);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int nw, ww, gw;
        for (int i = 7; i >= 0; i--) begin
            nw = $urandom_range(SMAX, PMIN);
            ww = $urandom_range(20, SMAX + 1);
            gw = $urandom_range(8, 1);
            pulse(b[i] ? ww : nw);
            gap(gw);
        end
`ifdef BARCODE_RX_PARITY_EN
        pulse((^b) ? 20 : 5);
        gap(5);
`endif
    endtask

    task automatic compareQueues(input string tag);
        int n;
        repeat (4) @(posedge CLK);
        #1;
        checkOutput({tag, ".nbytes"}, gotBytes.size(), expBytes.size());
        n = (gotBytes.size() < expBytes.size()) ? gotBytes.size() : expBytes.size();
        for (int i = 0; i < n; i++) checkOutput({tag, ".byte"}, 32'(gotBytes[i]), 32'(expBytes[i]));
        checkOutput({tag, ".nerrs"}, gotErrs.size(), expErrs.size());
        n = (gotErrs.size() < expErrs.size()) ? gotErrs.size() : expErrs.size();
        for (int i = 0; i < n; i++) checkOutput({tag, ".errcode"}, 32'(gotErrs[i]), 32'(expErrs[i]));
        checkOutput({tag, ".overrun"}, gotOverrun, expOverrun);
        gotBytes.delete();
        expBytes.delete();
        gotErrs.delete();
        expErrs.delete();
        gotOverrun = 0;
        expOverrun = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".DATA"}, 32'(DATA), 0);
        checkOutput({tag, ".VALID"}, 32'(VALID), 0);
        checkOutput({tag, ".ERR"}, 32'(ERR), 0);
        checkOutput({tag, ".ERRCODE"}, 32'(ERRCODE), 0);
        checkOutput({tag, ".OVERRUN"}, 32'(OVERRUN), 0);
        checkOutput({tag, ".BUSY"}, 32'(BUSY), 0);
    endtask

    initial begin
        logic [7:0] rb;
        int kind, k;
        RST = 1'b1;
        RXIN = 1'b0;
        setReady(0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        checkAllZero("reset");

        sendByte(8'hA3, 5, 20, 5);
        checkOutput("a3.VALID", 32'(VALID), 1);
        checkOutput("a3.DATA", 32'(DATA), 32'h A3);
        setReady(1);
        @(posedge CLK);
        #1;
        setReady(0);
        checkOutput("a3.VALIDcleared", 32'(VALID), 0);
        compareQueues("a3");
        setReady(1);

        sendBits(8'hA0, 3);
        checkOutput("short.BUSYmid", 32'(BUSY), 1);
        pulse(1);
        gap(5);
        checkOutput("short.BUSY", 32'(BUSY), 0);
        sendByte(8'h5A, 5, 20, 5);
        compareQueues("short");

        pulse(50);
        gap(5);
        sendByte(8'h3C, 5, 20, 5);
        compareQueues("long");

        sendBits(8'hB0, 4);
        gap(70);
        checkOutput("gap.VALID", 32'(VALID), 0);
        compareQueues("gap");

        setReady(0);
        sendByte(8'h55, 5, 20, 5);
        sendByte(8'hFF, 5, 20, 5);
        checkOutput("ovr.DATA", 32'(DATA), 32'h55);
        checkOutput("ovr.VALID", 32'(VALID), 1);
        setReady(1);
        compareQueues("overrun");

        sendByte(8'h96, SMAX, SMAX + 1, GMAX - 1);
        sendByte(8'h69, PMIN, PMAX, 1);
        compareQueues("bounds");

`ifdef BARCODE_RX_PARITY_EN
        sendByte(8'h0F, 5, 20, 5);
        sendBits(8'h0F, 8);
        pulse(20);
        gap(5);
        compareQueues("parity");
`endif

        sendBits(8'hE8, 5);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mBits = 0;
        modelFull = 0;
        checkAllZero("midreset");
        sendByte(8'hC3, 5, 20, 5);
        compareQueues("afterreset");

        for (int it = 0; it < 25; it++) begin
            rb = 8'($urandom);
            kind = $urandom_range(5, 0);
            k = $urandom_range(6, 1);
            case (kind)
                0: begin sendBits(rb, k); pulse(1); gap(3); end
                1: begin sendBits(rb, k); pulse($urandom_range(60, PMAX + 1)); gap(3); end
                2: begin sendBits(rb, k); gap($urandom_range(GMAX + 6, GMAX)); end
                default: applyStimulus(rb);
            endcase
            compareQueues("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
